lane_gather16: RTL and testbench

LANE_GATHER16 -- requirements
Module: lane_gather16

---
 rtl/fft_pkg.sv | 21 ++
 rtl/lane_gather16_bank.sv | 51 +++++
 rtl/lane_gather16.sv | 105 ++++++++++
 tb/tb_lane_gather16.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants, bank selector type and lane-order helpers for the 16-lane gather block.
package fft_pkg;

    localparam int D_WIDTH_DEF = 64;
    localparam int LANES       = 16;
    localparam int IDX_W       = 4;

    typedef enum logic {
        BANK_PING = 1'b0,
        BANK_PONG = 1'b1
    } bank_sel_e;

    function automatic bank_sel_e other_bank(input bank_sel_e b);
        return (b == BANK_PING) ? BANK_PONG : BANK_PING;
    endfunction

    function automatic logic [IDX_W-1:0] bitrev4(input logic [IDX_W-1:0] k);
        return {k[0], k[1], k[2], k[3]};
    endfunction

endpackage

// File: rtl/lane_gather16_bank.sv
// One frame bank: 16 lane registers written one lane at a time, plus a full flag.
module gather_bank #(
    parameter int D_WIDTH = fft_pkg::D_WIDTH_DEF
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  wr_en_i,
    input  logic [fft_pkg::IDX_W-1:0]             wr_lane_i,
    input  logic [D_WIDTH-1:0]                    wr_data_i,
    input  logic                                  set_full_i,
    input  logic                                  clr_full_i,
    output logic                                  full_o,
    output logic [fft_pkg::LANES*D_WIDTH-1:0]     data_o
);
    import fft_pkg::*;

    logic [D_WIDTH-1:0] lane_q [LANES];
    logic               full_q;
    logic               full_d;

    // The top never sets and clears the same bank in one cycle; set wins regardless.
    always_comb begin
        full_d = full_q;
        if (set_full_i) begin
            full_d = 1'b1;
        end else if (clr_full_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                lane_q[i] <= '0;
            end
        end else begin
            full_q <= full_d;
            if (wr_en_i) begin
                lane_q[wr_lane_i] <= wr_data_i;
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_pack
        assign data_o[g*D_WIDTH +: D_WIDTH] = lane_q[g];
    end

    assign full_o = full_q;

endmodule

// File: rtl/lane_gather16.sv
// Serial-to-16-lane frame gatherer with ping/pong banks; define GATHER_DIGIT_REV_EN
// to store sample k of each frame in lane bitrev4(k) instead of lane k.
module lane_gather16 #(
    parameter int D_WIDTH = fft_pkg::D_WIDTH_DEF,
    parameter int LANES   = fft_pkg::LANES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_sop,
    input  logic [D_WIDTH-1:0]       in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*D_WIDTH-1:0] out_data,
    output logic                     drop_err
);
    import fft_pkg::*;

    function automatic logic [IDX_W-1:0] lane_map(input logic [IDX_W-1:0] k);
`ifdef GATHER_DIGIT_REV_EN
        return bitrev4(k);
`else
        return k;
`endif
    endfunction

    bank_sel_e          fill_ptr_q, fill_ptr_d;
    bank_sel_e          rd_ptr_q, rd_ptr_d;
    logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
    logic               drop_err_q, drop_err_d;

    logic               ping_full, pong_full;
    logic [LANES*D_WIDTH-1:0] ping_data, pong_data;
    logic               fill_full, accept, restart, last, pop;
    logic [IDX_W-1:0]   wr_lane;

    always_comb begin
        fill_full  = (fill_ptr_q == BANK_PING) ? ping_full : pong_full;
        // Reset gating keeps ready low during reset; otherwise ready depends only on the full flags.
        in_ready   = !rst && !fill_full;
        out_valid  = (rd_ptr_q == BANK_PING) ? ping_full : pong_full;
        out_data   = (rd_ptr_q == BANK_PING) ? ping_data : pong_data;
        accept     = in_valid && in_ready;
        restart    = accept && in_sop && (wr_idx_q != '0);
        last       = accept && !restart && (wr_idx_q == IDX_W'(LANES - 1));
        pop        = out_valid && out_ready;
        wr_lane    = lane_map(restart ? '0 : wr_idx_q);

        wr_idx_d   = wr_idx_q;
        fill_ptr_d = fill_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        drop_err_d = restart;
        if (accept) begin
            wr_idx_d = restart ? IDX_W'(1) : wr_idx_q + IDX_W'(1);
        end
        if (last) begin
            fill_ptr_d = other_bank(fill_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = other_bank(rd_ptr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_ptr_q <= BANK_PING;
            rd_ptr_q   <= BANK_PING;
            wr_idx_q   <= '0;
            drop_err_q <= 1'b0;
        end else begin
            fill_ptr_q <= fill_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_idx_q   <= wr_idx_d;
            drop_err_q <= drop_err_d;
        end
    end

    assign drop_err = drop_err_q;

    gather_bank #(.D_WIDTH(D_WIDTH)) u_ping (
        .clk_i      (clk),
        .rst_i      (rst),
        .wr_en_i    (accept && (fill_ptr_q == BANK_PING)),
        .wr_lane_i  (wr_lane),
        .wr_data_i  (in_data),
        .set_full_i (last && (fill_ptr_q == BANK_PING)),
        .clr_full_i (pop && (rd_ptr_q == BANK_PING)),
        .full_o     (ping_full),
        .data_o     (ping_data)
    );

    gather_bank #(.D_WIDTH(D_WIDTH)) u_pong (
        .clk_i      (clk),
        .rst_i      (rst),
        .wr_en_i    (accept && (fill_ptr_q == BANK_PONG)),
        .wr_lane_i  (wr_lane),
        .wr_data_i  (in_data),
        .set_full_i (last && (fill_ptr_q == BANK_PONG)),
        .clr_full_i (pop && (rd_ptr_q == BANK_PONG)),
        .full_o     (pong_full),
        .data_o     (pong_data)
    );

endmodule

// File: tb/tb_lane_gather16.sv
// Scoreboard bench for lane_gather16: drivers push expected frames, a negedge monitor pops and compares.
module tb_lane_gather16;
    localparam int D  = 64;
    localparam int FW = 16 * D;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_sop = 1'b0;
    logic [D-1:0]  in_data = '0;
    logic          out_ready = 1'b0;
    logic          in_ready, out_valid, drop_err;
    logic [FW-1:0] out_data;

    lane_gather16 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sop    (in_sop),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .drop_err  (drop_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [FW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail = 0;
    int frames_out = 0;
    int drops_seen = 0;
    int n_accepted = 0;
    int ready_lows = 0;
    bit streaming = 1'b0;
    bit drv_done = 1'b0;
    bit rnd_on = 1'b0;
    logic [D-1:0]  last_lane0 = '0;
    logic          held_v = 1'b0;
    logic [FW-1:0] held_d = '0;
    logic [FW-1:0] mon_e;
    int            mon_first;

    logic [FW-1:0] m_frame = '0;
    int            m_idx = 0;

    function automatic int lane_of(input int k);
        logic [3:0] b;
        b = k[3:0];
`ifdef GATHER_DIGIT_REV_EN
        return int'({b[0], b[1], b[2], b[3]});
`else
        return int'(b);
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_accept(input logic [D-1:0] d, input logic sop);
        n_accepted++;
        if (sop && m_idx != 0) begin
            m_frame[lane_of(0)*D +: D] = d;
            m_idx = 1;
        end else begin
            m_frame[lane_of(m_idx)*D +: D] = d;
            m_idx++;
            if (m_idx == 16) begin
                exp_q.push_back(m_frame);
                m_idx = 0;
            end
        end
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the sample.
    task automatic send(input logic [D-1:0] d, input logic sop);
        int  waited;
        bit  got;
        waited = 0;
        got = 1'b0;
        in_valid = 1'b1;
        in_data = d;
        in_sop = sop;
        while (!got && waited < 300) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
            else waited++;
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: actual=in_ready low for %0d cycles required=accept", waited);
            in_valid = 1'b0;
        end else begin
            model_accept(d, sop);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_sop = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        idle();
        @(negedge clk);
        chk("in_ready_during_reset", 64'(in_ready), 64'd0);
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        m_idx = 0;
        m_frame = '0;
        @(negedge clk);
        chk("in_ready_after_reset", 64'(in_ready), 64'd1);
        chk("out_valid_after_reset", 64'(out_valid), 64'd0);
        chk("out_data_zero_after_reset", 64'(|out_data), 64'd0);
        chk("drop_err_after_reset", 64'(drop_err), 64'd0);
        tick(1);
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 200) begin
            tick(1);
            w++;
        end
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: pops on every transfer and checks that a stalled frame does not move.
    always @(negedge clk) begin
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                n_checks++;
                if (!out_valid || out_data !== held_d) begin
                    n_fail++;
                    $display("FAIL hold_stable: actual valid=%0b lane0=%0h required valid=1 lane0=%0h",
                             out_valid, out_data[D-1:0], held_d[D-1:0]);
                end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                frames_out++;
                last_lane0 = out_data[lane_of(0)*D +: D];
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL frame_unexpected: actual=frame lane0 %0h required=no frame", out_data[D-1:0]);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (out_data !== mon_e) begin
                        n_fail++;
                        mon_first = 0;
                        for (int i = 15; i >= 0; i--) begin
                            if (out_data[i*D +: D] !== mon_e[i*D +: D]) mon_first = i;
                        end
                        $display("FAIL frame lane %0d: actual=%0h expected=%0h", mon_first,
                                 out_data[mon_first*D +: D], mon_e[mon_first*D +: D]);
                    end
                end
            end
            held_v = out_valid && !out_ready;
            held_d = out_data;
            if (drop_err) drops_seen++;
            if (streaming && !in_ready) ready_lows++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=simulation still running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int f0, d0, c0;

        // Natural fill: samples 0..15 with in_data = k, 1-cycle latency to out_valid.
        do_reset(2);
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) send(64'(k), k == 0);
        idle();
        @(negedge clk);
        chk("out_valid_latency", 64'(out_valid), 64'd1);
        chk("lane5_value", out_data[lane_of(5)*D +: D], 64'd5);
        chk("lane15_value", out_data[lane_of(15)*D +: D], 64'd15);
        tick(1);
        wait_drain();

        // Backpressure: 40 samples with out_ready low, two frames held.
        do_reset(2);
        out_ready = 1'b0;
        n_accepted = 0;
        f0 = frames_out;
        drv_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) send(64'h1000 + 64'(i), i == 0);
                idle();
                drv_done = 1'b1;
            end
        join_none
        tick(50);
        @(negedge clk);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        chk("bp_accepted_32", 64'(n_accepted), 64'd32);
        chk("bp_frames_held", 64'(exp_q.size()), 64'd2);
        tick(1);
        out_ready = 1'b1;
        begin
            int w;
            w = 0;
            while (!drv_done && w < 200) begin
                tick(1);
                w++;
            end
        end
        chk("bp_driver_done", 64'(drv_done), 64'd1);
        wait_drain();
        chk("bp_accepted_40", 64'(n_accepted), 64'd40);
        chk("bp_two_frames_out", 64'(frames_out - f0), 64'd2);
        @(negedge clk);
        chk("bp_in_ready_back", 64'(in_ready), 64'd1);
        tick(1);

        // Streaming: 160 samples back to back.
        do_reset(2);
        out_ready = 1'b1;
        f0 = frames_out;
        ready_lows = 0;
        streaming = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 160; i++) send(64'(i * 3 + 7), (i % 16) == 0);
        idle();
        streaming = 1'b0;
        chk("stream_cycles", 64'(cyc - c0), 64'd160);
        wait_drain();
        tick(2);
        chk("stream_ten_frames", 64'(frames_out - f0), 64'd10);
        chk("stream_no_ready_drop", 64'(ready_lows), 64'd0);

        // Early sop: partial frame dropped, new frame starts with 0xAA.
        do_reset(2);
        out_ready = 1'b1;
        d0 = drops_seen;
        for (int i = 0; i < 5; i++) send(64'h300 + 64'(i), i == 0);
        send(64'hAA, 1'b1);
        for (int i = 0; i < 15; i++) send(64'h310 + 64'(i), 1'b0);
        idle();
        wait_drain();
        tick(1);
        chk("sop_drop_pulses", 64'(drops_seen - d0), 64'd1);
        chk("sop_lane0_aa", last_lane0, 64'hAA);

        // Reset with one full bank pending and 9 samples in the other.
        do_reset(2);
        out_ready = 1'b0;
        for (int i = 0; i < 25; i++) send(64'h2000 + 64'(i), i == 0);
        idle();
        @(negedge clk);
        chk("pending_before_reset", 64'(out_valid), 64'd1);
        tick(1);
        f0 = frames_out;
        do_reset(1);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) send(64'h4000 + 64'(i), i == 0);
        idle();
        wait_drain();
        chk("post_reset_one_frame", 64'(frames_out - f0), 64'd1);

        // Random out_ready while frames are presented.
        do_reset(2);
        f0 = frames_out;
        rnd_on = 1'b1;
        fork
            begin
                while (rnd_on) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join_none
        for (int i = 0; i < 48; i++) send(64'h5000 + 64'(i * 17), (i % 16) == 0);
        idle();
        rnd_on = 1'b0;
        tick(2);
        out_ready = 1'b1;
        wait_drain();
        chk("random_three_frames", 64'(frames_out - f0), 64'd3);

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
